inst_rom_loader: RTL and testbench



---
 rtl/inst_rom_loader_pkg.sv | 32 +++
 rtl/inst_rom_loader_ld_word_asm.sv | 39 +++
 rtl/inst_rom_loader.sv | 139 +++++++++++++
 tb/tb_inst_rom_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader.
//   - Bus types and constants inherited from the CPU core's defines.
//   - Default memory depth (log2, in words).
//   - Load-port FSM state encoding.
//   - Header length validation helper.
package inst_rom_loader_pkg;

    localparam int unsigned InstMemNumLog2 = 10;

    typedef logic [31:0] InstBus;
    typedef logic [31:0] InstAddrBus;

    localparam InstBus ZeroWord    = '0;
    localparam logic   RstEnable   = 1'b1;
    localparam logic   ChipEnable  = 1'b1;
    localparam logic   ChipDisable = 1'b0;

    typedef enum logic [2:0] {
        LdIdle,
        LdLenHi,
        LdLenLo,
        LdData,
        LdDone,
        LdErr
    } ld_state_e;

    // A header is usable when it asks for 1..2**addr_w words.
    function automatic logic len_ok(input logic [15:0] len, input int unsigned addr_w);
        return (len != 16'd0) && (32'(len) <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/inst_rom_loader_ld_word_asm.sv
// Byte counter plus big-endian 4-to-1 word assembler for the load port.
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : restart assembly at byte 0 (new load session)
//   byte_vld_i   : a data byte is accepted this cycle
//   byte_i       : the data byte
//   word_o       : assembled word, including the current byte (first byte in [31:24])
//   word_vld_o   : high in the cycle the 4th byte of a word is accepted
module ld_word_asm
    import inst_rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_vld_o
);

    logic [1:0]  cnt;
    logic [23:0] acc;

    always_ff @(posedge clk) begin
        if (rst == RstEnable || clr_i) begin
            cnt <= '0;
            acc <= '0;
        end else if (byte_vld_i) begin
            cnt <= cnt + 2'd1;
            acc <= {acc[15:0], byte_i};
        end
    end

    // The 4th byte bypasses the accumulator so the word can be written on the same edge.
    always_comb begin
        word_o     = {acc, byte_i};
        word_vld_o = byte_vld_i && (cnt == 2'd3);
    end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory for the CPU fetch port, loaded at run time over a byte-serial port.
//   clk, rst         : clock, synchronous active-high reset
//   ce_i, addr_i     : fetch enable and byte address from the core
//   inst_o           : combinational instruction word (0 when disabled, out of range, or holding)
//   ld_start_i       : begin a load session (honoured in IDLE/DONE/ERR only)
//   ld_valid_i/byte_i: load byte stream: 16-bit length header (MSB first), then big-endian words
//   ld_ready_o       : byte accepted this cycle when ld_valid_i is high
//   ld_done_o        : last load completed
//   ld_err_o         : last header rejected
//   cpu_hold_o       : keeps the core in reset while a load is in progress
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = InstMemNumLog2,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  InstAddrBus        addr_i,
    output logic [INST_W-1:0] inst_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    output logic              ld_ready_o,
    output logic              ld_done_o,
    output logic              ld_err_o,
    output logic              cpu_hold_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    ld_state_e          state, state_nxt;
    logic [15:0]        len, len_nxt;
    logic [ADDR_W:0]    ptr, ptr_nxt;
    logic               done_nxt, err_nxt, hold_nxt;
    logic               start_load;
    logic               byte_acc;
    logic [INST_W-1:0]  asm_word;
    logic               asm_vld;
    logic [INST_W-1:0]  mem [DEPTH];

    ld_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (start_load),
        .byte_vld_i (byte_acc && (state == LdData)),
        .byte_i     (ld_byte_i),
        .word_o     (asm_word),
        .word_vld_o (asm_vld)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state      <= LdIdle;
            len        <= '0;
            ptr        <= '0;
            ld_done_o  <= 1'b0;
            ld_err_o   <= 1'b0;
            cpu_hold_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            len        <= len_nxt;
            ptr        <= ptr_nxt;
            ld_done_o  <= done_nxt;
            ld_err_o   <= err_nxt;
            cpu_hold_o <= hold_nxt;
        end
    end

    // Memory is deliberately not reset: an aborted load keeps the words it already wrote.
    always_ff @(posedge clk) begin
        if (asm_vld)
            mem[ptr[ADDR_W-1:0]] <= asm_word;
    end

    always_comb begin
        ld_ready_o = (state == LdLenHi) || (state == LdLenLo) || (state == LdData);
        byte_acc   = ld_valid_i && ld_ready_o;
        state_nxt  = state;
        len_nxt    = len;
        ptr_nxt    = ptr;
        done_nxt   = ld_done_o;
        err_nxt    = ld_err_o;
        hold_nxt   = cpu_hold_o;
        start_load = 1'b0;

        unique case (state)
            LdIdle, LdDone, LdErr: begin
                if (ld_start_i) begin
                    state_nxt  = LdLenHi;
                    start_load = 1'b1;
                    ptr_nxt    = '0;
                    done_nxt   = 1'b0;
                    err_nxt    = 1'b0;
                    hold_nxt   = 1'b1;
                end
            end
            LdLenHi: begin
                if (byte_acc) begin
                    len_nxt[15:8] = ld_byte_i;
                    state_nxt     = LdLenLo;
                end
            end
            LdLenLo: begin
                if (byte_acc) begin
                    len_nxt[7:0] = ld_byte_i;
                    if (len_ok({len[15:8], ld_byte_i}, ADDR_W)) begin
                        state_nxt = LdData;
                    end else begin
                        state_nxt = LdErr;
                        err_nxt   = 1'b1;
                        hold_nxt  = 1'b0;
                    end
                end
            end
            LdData: begin
                if (asm_vld) begin
                    ptr_nxt = ptr + 1'b1;
                    if (32'(ptr) + 32'd1 == 32'(len)) begin
                        state_nxt = LdDone;
                        done_nxt  = 1'b1;
                        hold_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = LdIdle;
        endcase
    end

    // Shifting the whole address both range-checks the upper bits and discards the byte offset.
    always_comb begin
        if (ce_i == ChipEnable && !cpu_hold_o && (addr_i >> (ADDR_W + 2)) == '0)
            inst_o = mem[addr_i[ADDR_W+1:2]];
        else
            inst_o = ZeroWord;
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic [31:0] addr_i;
    logic [31:0] inst_o;
    logic        ld_start_i;
    logic        ld_valid_i;
    logic [7:0]  ld_byte_i;
    logic        ld_ready_o;
    logic        ld_done_o;
    logic        ld_err_o;
    logic        cpu_hold_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: expected memory contents, updated once a whole word has been sent.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] payload [DEPTH];

    always #5 clk = ~clk;

    inst_rom_loader #(.ADDR_W(AW), .INST_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .inst_o     (inst_o),
        .ld_start_i (ld_start_i),
        .ld_valid_i (ld_valid_i),
        .ld_byte_i  (ld_byte_i),
        .ld_ready_o (ld_ready_o),
        .ld_done_o  (ld_done_o),
        .ld_err_o   (ld_err_o),
        .cpu_hold_o (cpu_hold_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic rdy, input logic done,
                               input logic err, input logic hold);
        check({tag, "_ready"}, 32'(ld_ready_o), 32'(rdy));
        check({tag, "_done"},  32'(ld_done_o),  32'(done));
        check({tag, "_err"},   32'(ld_err_o),   32'(err));
        check({tag, "_hold"},  32'(cpu_hold_o), 32'(hold));
    endtask

    // Called at a negedge; returns at the negedge after the byte was consumed.
    task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
        int unsigned n;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        ld_valid_i = 1'b1;
        ld_byte_i  = b;
        n = 0;
        while (ld_ready_o !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n == 64) check("ready_wait", 32'(ld_ready_o), 32'd1);
        @(negedge clk);
        ld_valid_i = 1'b0;
        ld_byte_i  = 8'($urandom);
    endtask

    task automatic send_header(input logic [15:0] len, input int unsigned gap);
        send_byte(len[15:8], gap);
        send_byte(len[7:0], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap);
    endtask

    task automatic pulse_start();
        ld_start_i = 1'b1;
        @(negedge clk);
        ld_start_i = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic ce, output logic [31:0] d);
        ce_i   = ce;
        addr_i = a;
        #1;
        d = inst_o;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;

        rst = 1'b1; ce_i = 1'b0; addr_i = '0;
        ld_start_i = 1'b0; ld_valid_i = 1'b0; ld_byte_i = '0;
        repeat (3) @(negedge clk);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Full-depth load with random valid gaps.
        for (int i = 0; i < int'(DEPTH); i++) payload[i] = $urandom;
        pulse_start();
        check_flags("full_start", 1'b1, 1'b0, 1'b0, 1'b1);
        send_header(16'h0400, 2);
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            send_word(payload[i], 2);
            ref_mem[i] = payload[i];
        end
        for (int k = 0; k < 3; k++) send_byte(payload[DEPTH-1][31-8*k -: 8], 2);
        check_flags("full_before_last", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(payload[DEPTH-1][7:0], 2);
        ref_mem[DEPTH-1] = payload[DEPTH-1];
        check_flags("full_after_last", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            fetch(32'(i) * 4, 1'b1, d);
            check($sformatf("full_word%0d", i), d, ref_mem[i]);
        end
        @(negedge clk);

        // Reset in the middle of DATA: word 0 complete, word 1 half sent.
        pulse_start();
        send_header(16'h0004, 0);
        send_word(32'h24010001, 0);
        ref_mem[0] = 32'h24010001;
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_flags("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
        fetch(32'h0, 1'b1, d); check("midreset_w0", d, ref_mem[0]);
        fetch(32'h4, 1'b1, d); check("midreset_w1", d, ref_mem[1]);
        fetch(32'h8, 1'b1, d); check("midreset_w2", d, ref_mem[2]);
        @(negedge clk);

        // Two-word load.
        pulse_start();
        send_header(16'h0002, 1);
        send_word(32'h34011100, 1);
        ref_mem[0] = 32'h34011100;
        for (int k = 0; k < 3; k++) send_byte(8'(32'h34020020 >> (24 - 8*k)), 1);
        check_flags("two_before_last", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h20, 1);
        ref_mem[1] = 32'h34020020;
        check_flags("two_after_last", 1'b0, 1'b1, 1'b0, 1'b0);
        fetch(32'h4, 1'b1, d);        check("fetch_addr4", d, 32'h34020020);
        fetch(32'h0, 1'b0, d);        check("fetch_ce0", d, 32'h0);
        fetch(32'h00001000, 1'b1, d); check("fetch_out_of_range", d, 32'h0);
        fetch(32'h80000004, 1'b1, d); check("fetch_high_bit", d, 32'h0);
        fetch(32'h3, 1'b1, d);        check("fetch_addr3", d, 32'h34011100);
        fetch(32'hFFC, 1'b1, d);      check("fetch_top", d, ref_mem[DEPTH-1]);
        fetch(32'h8, 1'b1, d);        check("fetch_above_len", d, ref_mem[2]);
        @(negedge clk);

        // Zero-length header.
        pulse_start();
        check_flags("zero_start", 1'b1, 1'b0, 1'b0, 1'b1);
        send_header(16'h0000, 0);
        check_flags("zero_len", 1'b0, 1'b0, 1'b1, 1'b0);

        // Oversized header from ERR; memory must be untouched.
        pulse_start();
        check_flags("big_start", 1'b1, 1'b0, 1'b0, 1'b1);
        send_header(16'h0401, 0);
        check_flags("big_len", 1'b0, 1'b0, 1'b1, 1'b0);
        fetch(32'h0, 1'b1, d); check("big_w0", d, ref_mem[0]);
        fetch(32'h4, 1'b1, d); check("big_w1", d, ref_mem[1]);
        fetch(32'h8, 1'b1, d); check("big_w2", d, ref_mem[2]);
        @(negedge clk);

        // Start pulse during DATA must not restart the session.
        pulse_start();
        send_header(16'h0002, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hA2, 0);
        fetch(32'h0, 1'b1, d); check("hold_masks_fetch", d, 32'h0);
        pulse_start();
        send_byte(8'hA3, 0);
        send_byte(8'hA4, 0);
        ref_mem[0] = 32'hA1A2A3A4;
        send_word(32'h0BADF00D, 0);
        ref_mem[1] = 32'h0BADF00D;
        check_flags("start_in_data", 1'b0, 1'b1, 1'b0, 1'b0);
        fetch(32'h0, 1'b1, d); check("start_in_data_w0", d, ref_mem[0]);
        fetch(32'h4, 1'b1, d); check("start_in_data_w1", d, ref_mem[1]);

        // Byte presented together with start in IDLE is ignored.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ld_start_i = 1'b1;
        ld_valid_i = 1'b1;
        ld_byte_i  = 8'hFF;
        @(negedge clk);
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        check_flags("idle_start_byte", 1'b1, 1'b0, 1'b0, 1'b1);
        send_header(16'h0001, 0);
        send_word(32'hDEADBEEF, 0);
        ref_mem[0] = 32'hDEADBEEF;
        check_flags("one_word", 1'b0, 1'b1, 1'b0, 1'b0);
        fetch(32'h0, 1'b1, d); check("one_word_w0", d, ref_mem[0]);
        fetch(32'h4, 1'b1, d); check("one_word_w1", d, ref_mem[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
